// File: rtl/servo_pwm_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | servo_pwm_decoder - measures servo pulse high time and maps it to a code   |
// | Build macro PWM_DEC_FILTER_EN: update only on two matching consecutive codes |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module servo_pwm_decoder #(
  parameter int TICK_DIV       = 6250,
  parameter int TIMEOUT_TICKS  = 162,
  parameter int MAX_HIGH_TICKS = 16
) (
  input  logic       Pixelclock,
  input  logic       reset,
  input  logic       Servo_PWM,
  output logic [7:0] character,
  output logic [4:0] width,
  output logic       valid,
  output logic       err,
  output logic       lost
);

  localparam int c_SW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_TMAX = (TIMEOUT_TICKS > MAX_HIGH_TICKS + 1) ? TIMEOUT_TICKS : MAX_HIGH_TICKS + 1;
  localparam int c_TW   = $clog2(c_TMAX + 1);

  localparam logic [c_SW-1:0] c_SUB_LAST = c_SW'(TICK_DIV - 1);
  localparam logic [c_SW-1:0] c_SUB_HALF = c_SW'(TICK_DIV / 2);
  localparam logic [c_TW-1:0] c_TIMEOUT  = c_TW'(TIMEOUT_TICKS);
  localparam logic [c_TW-1:0] c_MAX_HIGH = c_TW'(MAX_HIGH_TICKS);

  localparam logic [1:0] c_S_WAIT_LOW = 2'd0;
  localparam logic [1:0] c_S_LOW      = 2'd1;
  localparam logic [1:0] c_S_HIGH     = 2'd2;
  localparam logic [1:0] c_S_OVER     = 2'd3;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [1:0]       r_arm;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nx;
  logic [c_SW-1:0]  r_sub;
  logic [c_TW-1:0]  r_ticks;
  logic             r_lost;
  logic             r_evt_done;
  logic             r_evt_ovl;
  logic [4:0]       r_evt_width;
  logic [7:0]       r_char;
  logic [4:0]       r_width;
  logic             r_valid;
  logic             r_err;

  logic             w_rise;
  logic             w_fall;
  logic             w_sub_wrap;
  logic [c_SW-1:0]  w_sub_nx;
  logic [c_TW-1:0]  w_ticks_nx;
  logic             w_round;
  logic [31:0]      w_meas_full;
  logic [4:0]       w_meas;
  logic             w_ovl;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_done;
  logic             w_ovl_evt;
  logic             w_lost_set;
  logic             w_lost_clr;
  logic [7:0]       w_code;
  logic             w_code_ok;

  // r_arm keeps WAIT_LOW from trusting the synchronizer until reset zeros have flushed out
  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_arm   <= 2'd0;
    end else begin
      r_sync1 <= Servo_PWM;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_arm != 2'd3) r_arm <= r_arm + 2'd1;
    end
  end

  assign w_rise = r_sync2 & ~r_prev;
  assign w_fall = ~r_sync2 & r_prev;

  assign w_sub_wrap = (r_sub == c_SUB_LAST);
  assign w_sub_nx   = w_sub_wrap ? '0 : r_sub + 1'b1;
  assign w_ticks_nx = w_sub_wrap ? r_ticks + 1'b1 : r_ticks;

  // The falling-edge cycle still counts as high time, so round on the post-increment value
  assign w_round     = (w_sub_nx >= c_SUB_HALF);
  assign w_meas_full = 32'(w_ticks_nx) + 32'(w_round);
  assign w_meas      = (w_meas_full > 32'd31) ? 5'd31 : w_meas_full[4:0];
  assign w_ovl       = (r_ticks > c_MAX_HIGH);

  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) r_state <= c_S_WAIT_LOW;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      c_S_WAIT_LOW: if (r_arm == 2'd3 && !r_sync2) w_state_nx = c_S_LOW;
      c_S_LOW:      if (w_rise) w_state_nx = c_S_HIGH;
      c_S_HIGH: begin
        if (w_ovl)       w_state_nx = c_S_OVER;
        else if (w_fall) w_state_nx = c_S_LOW;
      end
      c_S_OVER:     if (w_fall) w_state_nx = c_S_LOW;
      default:      w_state_nx = c_S_WAIT_LOW;
    endcase
  end

  always_comb begin
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;
    w_done     = 1'b0;
    w_ovl_evt  = 1'b0;
    w_lost_set = 1'b0;
    w_lost_clr = 1'b0;
    case (r_state)
      c_S_WAIT_LOW: w_cnt_clr = 1'b1;
      c_S_LOW: begin
        if (w_rise) begin
          w_cnt_clr  = 1'b1;
          w_lost_clr = 1'b1;
        end else if (r_ticks == c_TIMEOUT) begin
          w_lost_set = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      c_S_HIGH: begin
        if (w_ovl) begin
          w_ovl_evt = 1'b1;
        end else if (w_fall) begin
          w_done    = 1'b1;
          w_cnt_clr = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      c_S_OVER: if (w_fall) w_cnt_clr = 1'b1;
      default:  w_cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) begin
      r_sub   <= '0;
      r_ticks <= '0;
    end else if (w_cnt_clr) begin
      r_sub   <= '0;
      r_ticks <= '0;
    end else if (w_cnt_inc) begin
      r_sub   <= w_sub_nx;
      r_ticks <= w_ticks_nx;
    end
  end

  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset)           r_lost <= 1'b0;
    else if (w_lost_clr) r_lost <= 1'b0;
    else if (w_lost_set) r_lost <= 1'b1;
  end

  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) begin
      r_evt_done  <= 1'b0;
      r_evt_ovl   <= 1'b0;
      r_evt_width <= 5'd0;
    end else begin
      r_evt_done <= w_done;
      r_evt_ovl  <= w_ovl_evt;
      if (w_done)         r_evt_width <= w_meas;
      else if (w_ovl_evt) r_evt_width <= 5'd31;
    end
  end

  always_comb begin
    w_code    = 8'h00;
    w_code_ok = 1'b0;
    case (r_evt_width)
      5'd5: begin w_code = 8'h2B; w_code_ok = 1'b1; end
      5'd6: begin w_code = 8'h15; w_code_ok = 1'b1; end
      5'd7: begin w_code = 8'h33; w_code_ok = 1'b1; end
      5'd9: begin w_code = 8'h22; w_code_ok = 1'b1; end
      default: ;
    endcase
  end

`ifdef PWM_DEC_FILTER_EN
  logic [7:0] r_cand;
  logic       r_cand_vld;

  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) begin
      r_char     <= 8'h00;
      r_width    <= 5'd0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_cand     <= 8'h00;
      r_cand_vld <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (r_evt_done || r_evt_ovl) r_width <= r_evt_width;
      if (r_evt_ovl || (r_evt_done && !w_code_ok)) r_err <= 1'b1;
      if (r_evt_ovl || (r_evt_done && !w_code_ok) || r_lost) begin
        r_cand_vld <= 1'b0;
      end else if (r_evt_done) begin
        if (r_cand_vld && (r_cand == w_code)) begin
          r_char  <= w_code;
          r_valid <= 1'b1;
        end
        r_cand     <= w_code;
        r_cand_vld <= 1'b1;
      end
    end
  end
`else
  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) begin
      r_char  <= 8'h00;
      r_width <= 5'd0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (r_evt_done || r_evt_ovl) r_width <= r_evt_width;
      if (r_evt_ovl || (r_evt_done && !w_code_ok)) r_err <= 1'b1;
      if (r_evt_done && w_code_ok) begin
        r_char  <= w_code;
        r_valid <= 1'b1;
      end
    end
  end
`endif

  assign character = r_char;
  assign width     = r_width;
  assign valid     = r_valid;
  assign err       = r_err;
  assign lost      = r_lost;

endmodule
`default_nettype wire
